// File: rtl/i2s_xcvr.sv
// I2S master transceiver: 16-bit stereo DAC out, optional 16-bit stereo ADC in.
// Define I2S_ADC_EN to build the receive path; otherwise ADC outputs are tied to 0.
module i2s_xcvr #(
  parameter int BCK_HALF = 4
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic [15:0] pcm_l,
  input  logic [15:0] pcm_r,
  output logic        pcm_ld,
  output logic        mclk,
  output logic        bck,
  output logic        lrck,
  output logic        dacdat,
  input  logic        adcdat,
  output logic [15:0] adc_l,
  output logic [15:0] adc_r,
  output logic        adc_valid
);
  localparam int DW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  logic [DW-1:0] r_div;
  logic          r_mclk, r_bck, r_lrck, r_dacdat, r_pcm_ld;
  logic [5:0]    r_bit_cnt;
  logic [15:0]   r_sh_l, r_sh_r;

  logic          w_tick, w_fall, w_rise, w_dac;
  logic [5:0]    w_bit_nxt;
  logic [3:0]    w_idx;

  assign w_tick    = (r_div == DW'(BCK_HALF - 1));
  assign w_fall    = w_tick & r_bck;
  assign w_rise    = w_tick & ~r_bck;
  assign w_bit_nxt = r_bit_cnt + 6'd1;
  // Slots 1..16 and 33..48 share the low 5 bits, so one index serves both words.
  assign w_idx     = 4'(5'd16 - w_bit_nxt[4:0]);

  always_comb begin
    w_dac = 1'b0;
    if (w_bit_nxt >= 6'd1 && w_bit_nxt <= 6'd16)
      w_dac = r_sh_l[w_idx];
    else if (w_bit_nxt >= 6'd33 && w_bit_nxt <= 6'd48)
      w_dac = r_sh_r[w_idx];
  end

  always_ff @(posedge clk24) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_mclk    <= 1'b0;
      r_bck     <= 1'b0;
      r_lrck    <= 1'b0;
      r_dacdat  <= 1'b0;
      r_pcm_ld  <= 1'b0;
      r_bit_cnt <= '0;
      r_sh_l    <= '0;
      r_sh_r    <= '0;
    end else begin
      r_mclk   <= ~r_mclk;
      r_pcm_ld <= 1'b0;
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_bck <= ~r_bck;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_bit_nxt[5];
        r_dacdat  <= w_dac;
        if (w_bit_nxt == 6'd0) begin
          r_sh_l   <= pcm_l;
          r_sh_r   <= pcm_r;
          r_pcm_ld <= 1'b1;
        end
      end
    end
  end

  assign mclk   = r_mclk;
  assign bck    = r_bck;
  assign lrck   = r_lrck;
  assign dacdat = r_dacdat;
  assign pcm_ld = r_pcm_ld;

`ifdef I2S_ADC_EN
  logic [15:0] r_rx_l, r_rx_r, r_adc_l, r_adc_r;
  logic        r_adc_valid;

  // Sample on the rise: the codec drives each bit on the preceding fall.
  always_ff @(posedge clk24) begin
    if (!reset_n) begin
      r_rx_l      <= '0;
      r_rx_r      <= '0;
      r_adc_l     <= '0;
      r_adc_r     <= '0;
      r_adc_valid <= 1'b0;
    end else begin
      r_adc_valid <= 1'b0;
      if (w_rise) begin
        if (r_bit_cnt >= 6'd1 && r_bit_cnt <= 6'd16)
          r_rx_l <= {r_rx_l[14:0], adcdat};
        if (r_bit_cnt >= 6'd33 && r_bit_cnt <= 6'd48)
          r_rx_r <= {r_rx_r[14:0], adcdat};
        if (r_bit_cnt == 6'd48) begin
          r_adc_l     <= r_rx_l;
          r_adc_r     <= {r_rx_r[14:0], adcdat};
          r_adc_valid <= 1'b1;
        end
      end
    end
  end

  assign adc_l     = r_adc_l;
  assign adc_r     = r_adc_r;
  assign adc_valid = r_adc_valid;
`else
  logic w_unused_adc;
  assign w_unused_adc = adcdat ^ w_rise;
  assign adc_l     = '0;
  assign adc_r     = '0;
  assign adc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_xcvr.sv
// Directed bench for i2s_xcvr at BCK_HALF=4: reset, DAC frames, ADC frames,
// mid-frame pcm change and mid-frame reset. ADC expectations follow I2S_ADC_EN.
module tb_i2s_xcvr;
  logic        clk24 = 1'b0;
  logic        reset_n;
  logic [15:0] pcm_l, pcm_r;
  logic        pcm_ld, mclk, bck, lrck, dacdat, adcdat, adc_valid;
  logic [15:0] adc_l, adc_r;

  i2s_xcvr #(.BCK_HALF(4)) dut (
    .clk24(clk24), .reset_n(reset_n), .pcm_l(pcm_l), .pcm_r(pcm_r),
    .pcm_ld(pcm_ld), .mclk(mclk), .bck(bck), .lrck(lrck), .dacdat(dacdat),
    .adcdat(adcdat), .adc_l(adc_l), .adc_r(adc_r), .adc_valid(adc_valid)
  );

  always #20 clk24 = ~clk24;

  int n_chk = 0, n_fail = 0;
  int c;
  logic [15:0] m_sh_l, m_sh_r, m_adc_l, m_adc_r;
  logic [15:0] adc_lw = 16'h1234, adc_rw = 16'hFEDC;
  logic [63:0] cap [4];

`ifdef I2S_ADC_EN
  localparam bit ADC_ON = 1'b1;
`else
  localparam bit ADC_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (c=%0d)", tag, act, exp, c);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mclk"}, 32'(mclk), 0);
    chk({pfx, "_bck"}, 32'(bck), 0);
    chk({pfx, "_lrck"}, 32'(lrck), 0);
    chk({pfx, "_dacdat"}, 32'(dacdat), 0);
    chk({pfx, "_pcm_ld"}, 32'(pcm_ld), 0);
    chk({pfx, "_adc_valid"}, 32'(adc_valid), 0);
    chk({pfx, "_adc_l"}, 32'(adc_l), 0);
    chk({pfx, "_adc_r"}, 32'(adc_r), 0);
  endtask

  function automatic logic [15:0] word16(input logic [63:0] fr, input int base);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = fr[base+i];
    return w;
  endfunction

  // One clk24 cycle after release: compare every output with the cycle model.
  task automatic step();
    int n, e_dac;
    bit e_ld, e_av;
    @(posedge clk24); #1;
    c++;
    n    = (c / 8) % 64;
    e_ld = (c > 0) && (c % 512 == 0);
    e_av = ADC_ON && (c % 512 == 388);
    if (e_ld) begin m_sh_l = pcm_l; m_sh_r = pcm_r; end
    if (e_av) begin m_adc_l = adc_lw; m_adc_r = adc_rw; end
    if (n >= 1 && n <= 16)       e_dac = int'(m_sh_l[16-n]);
    else if (n >= 33 && n <= 48) e_dac = int'(m_sh_r[48-n]);
    else                         e_dac = 0;
    chk("mclk", 32'(mclk), 32'(c % 2));
    chk("bck", 32'(bck), 32'((c / 4) % 2));
    chk("lrck", 32'(lrck), 32'(n >= 32));
    chk("dacdat", 32'(dacdat), 32'(e_dac));
    chk("pcm_ld", 32'(pcm_ld), 32'(e_ld));
    chk("adc_valid", 32'(adc_valid), 32'(e_av));
    chk("adc_l", 32'(adc_l), 32'(m_adc_l));
    chk("adc_r", 32'(adc_r), 32'(m_adc_r));
    if (c % 8 == 0) begin
      if (c / 512 < 4) cap[c/512][n] = dacdat;
      if (n >= 1 && n <= 16)       adcdat = adc_lw[16-n];
      else if (n >= 33 && n <= 48) adcdat = adc_rw[48-n];
      else                         adcdat = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic release_rst();
    reset_n = 1'b1;
    c = 0;
    m_sh_l = '0; m_sh_r = '0; m_adc_l = '0; m_adc_r = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cap[i] = '0;
    reset_n = 1'b0; pcm_l = '0; pcm_r = '0; adcdat = 1'b0; c = 0;
    repeat (3) @(posedge clk24);
    #1;
    chk_zero("rst");

    release_rst();
    pcm_l = 16'hA5C3; pcm_r = 16'h8001;
    while (c < 1856) begin
      step();
      if (c == 576) pcm_l = 16'hFFFF;
    end

    chk("f0_left", 32'(word16(cap[0], 1)), 32'h0000);
    chk("f1_left", 32'(word16(cap[1], 1)), 32'hA5C3);
    chk("f1_gap", 32'(word16(cap[1], 17)), 32'h0000);
    chk("f1_right", 32'(word16(cap[1], 33)), 32'h8001);
    chk("f2_left", 32'(word16(cap[2], 1)), 32'hFFFF);
    chk("f2_right", 32'(word16(cap[2], 33)), 32'h8001);
    chk("f3_left", 32'(word16(cap[3], 1)), 32'hFFFF);

    // Reset at bit_cnt=40 of frame 3; adc_valid for this frame would have come 68 cycles later.
    reset_n = 1'b0;
    @(posedge clk24); #1;
    chk_zero("midrst");
    for (int i = 0; i < 80; i++) begin
      @(posedge clk24); #1;
      chk("midrst_adc_valid", 32'(adc_valid), 0);
      chk("midrst_pcm_ld", 32'(pcm_ld), 0);
    end

    release_rst();
    repeat (24) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_xcvr.md
I2S_XCVR -- requirements
Module: i2s_xcvr

Interface
REQ-001 The module SHALL have parameter BCK_HALF, default 4, meaning the number of clk24 cycles per BCK half-period (legal values 2..8).
REQ-002 The module SHALL have input clk24, width 1: the 24 MHz system clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have input reset_n, width 1: synchronous, active-low reset.
REQ-004 The module SHALL have input pcm_l, width 16: left DAC sample, two's complement.
REQ-005 The module SHALL have input pcm_r, width 16: right DAC sample, two's complement.
REQ-006 The module SHALL have output pcm_ld, width 1: a one-cycle pulse marking the clk24 cycle in which pcm_l and pcm_r were latched.
REQ-007 The module SHALL have outputs mclk, bck, lrck and dacdat, each width 1: codec master clock, bit clock, word clock and serial DAC data.
REQ-008 The module SHALL have input adcdat, width 1: serial ADC data from the codec.
REQ-009 The module SHALL have outputs adc_l and adc_r, each width 16: received ADC samples, two's complement.
REQ-010 The module SHALL have output adc_valid, width 1: a one-cycle pulse marking that adc_l and adc_r have been updated.

Function
REQ-011 mclk SHALL toggle on every clk24 cycle, giving 12 MHz.
REQ-012 A divider SHALL count 0..BCK_HALF-1; bck SHALL toggle on the cycle the divider wraps.
- A bck 1->0 transition is a "fall" event; a bck 0->1 transition is a "rise" event.
REQ-013 A 6-bit bit counter bit_cnt SHALL advance by 1 on every fall and wrap 63->0; one frame is 64 BCK periods, i.e. 512 clk24 cycles at BCK_HALF=4 (46.875 kHz).
REQ-014 On each fall, lrck SHALL be updated to 1 when the new bit_cnt is in 32..63, and to 0 otherwise (0 = left slot).
REQ-015 On the fall where bit_cnt wraps 63->0, pcm_l and pcm_r SHALL be copied into shadow registers, and pcm_ld SHALL be high for exactly that clk24 cycle.
REQ-016 On each fall, dacdat SHALL be driven according to the new bit_cnt (I2S format, MSB delayed one BCK after the lrck edge):
- bit_cnt n in 1..16: shadow_l[16-n].
- bit_cnt n in 33..48: shadow_r[48-n].
- all other bit_cnt values: 0.
REQ-017 dacdat, lrck and bit_cnt SHALL change only on fall cycles; they SHALL hold stable through each rise.
REQ-018 On each rise with bit_cnt in 1..16, adcdat SHALL be shifted MSB-first into a left shift register; with bit_cnt in 33..48, into a right shift register; at other bit_cnt values adcdat SHALL be ignored.
REQ-019 On the rise where bit_cnt is 48, after that cycle's shift, adc_l SHALL load the left shift register and adc_r SHALL load the right shift register in the same clk24 cycle, and adc_valid SHALL pulse high for that cycle.
REQ-020 A pcm_l or pcm_r change mid-frame SHALL NOT affect the frame in progress.
REQ-021 pcm_ld and adc_valid SHALL never be high in the same cycle; the fixed timing guarantees this, since they occur on different BCK edges.

Reset
REQ-022 While reset_n is 0, the following SHALL be 0 at the next clk24 edge: divider, bit_cnt, mclk, bck, lrck, dacdat, pcm_ld, adc_valid, adc_l, adc_r, both shift registers and both shadow registers.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately with no completing pcm_ld or adc_valid pulse.
- After release, the first fall occurs 2*BCK_HALF cycles later with bit_cnt=1.
- The first frame transmits zeros (shadows are 0).
- The first pcm_ld occurs 64 BCK periods after release (512 cycles at default).

Configuration
REQ-024 When macro I2S_ADC_EN is defined, the receive path of REQ-018/REQ-019 SHALL be present.
REQ-025 When I2S_ADC_EN is undefined, adc_l and adc_r SHALL be constant 0, adc_valid SHALL be constant 0, adcdat SHALL be unused, and no receive registers SHALL be synthesized; the transmit path SHALL be unaffected.

Verification
REQ-026 Reset scenario: hold reset_n=0 for 3 cycles, then release -> all outputs 0; first bck rise at cycle 4; first fall at cycle 8 with bit_cnt=1, dacdat=0; pcm_ld first at cycle 512.
REQ-027 DAC frame scenario: pcm_l=16'hA5C3, pcm_r=16'h8001, held across the pcm_ld -> dacdat reads 1010010111000011 at falls 1..16, zeros at falls 17..32, 1000000000000001 at falls 33..48; lrck rises on fall 32.
REQ-028 ADC frame scenario (I2S_ADC_EN): drive adcdat with 16'h1234 in left bits and 16'hFEDC in right bits -> adc_l=16'h1234 and adc_r=16'hFEDC with a single adc_valid pulse on the bit-48 rise.
REQ-029 Mid-frame change scenario: change pcm_l to 16'hFFFF at bit_cnt=8 -> the current frame still shifts the old value; the next frame shifts all ones.
REQ-030 Mid-frame reset scenario: assert reset_n=0 at bit_cnt=40 -> next cycle all outputs 0; no adc_valid pulse for that frame.
REQ-031 Macro-off scenario: build without I2S_ADC_EN and toggle adcdat randomly -> adc_l, adc_r and adc_valid stay 0; dacdat identical to the REQ-027 result.
